// File: rtl/alu_hilo_unit.sv
// -----------------------------------------------------------------------------
// alu_hilo_unit
//   Execute-stage ALU with an attached HI/LO register pair.
//   Single-cycle ops (logic, arithmetic, shifts, compares, MFHI/MFLO) finish
//   one cycle after start. MULT/MULTU/MADD/MADDU go through an iterative
//   shift-add multiplier that holds busy high until the product is committed.
//
//   Handshake: start is sampled on a rising edge only while busy=0. A sampled
//   start is accepted unconditionally. done is a one-cycle pulse in the cycle
//   where result/zero/overflow/invalid (and HI/LO for multiplies) become valid.
//   result, zero and overflow hold until the next done or reset.
//
// Parameters
//   BITS_PER_CYCLE  multiplier bits retired per iteration (1, 2 or 4)
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous reset, active-high
//   start        in   op request
//   alu_control  in   6-bit op code
//   a, b         in   32-bit operands (rs, rt)
//   shamt        in   shift amount for SLL/SRL/SRA
//   busy         out  multiplier active
//   done         out  completion pulse
//   result       out  registered result
//   zero         out  result == 0
//   overflow     out  signed overflow for ADD/SUB
//   invalid      out  unsupported op code pulse (with done)
//   hi_out       out  HI register
//   lo_out       out  LO register
// -----------------------------------------------------------------------------
module alu_hilo_unit #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  alu_control,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        invalid,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int K = 32 / BITS_PER_CYCLE;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MUL    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [5:0] OP_SLL   = 6'b000000;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_SRA   = 6'b000011;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_MADD  = 6'b011100;
    localparam logic [5:0] OP_MADDU = 6'b011101;
    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_ADDU  = 6'b100001;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_SUBU  = 6'b100011;
    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_XOR   = 6'b100110;
    localparam logic [5:0] OP_NOR   = 6'b100111;
    localparam logic [5:0] OP_NOT   = 6'b101000;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_SLTU  = 6'b101011;

    // FSM and multiplier state; 'state' is the observable FSM state.
    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [63:0] mcand;     // |a|, shifted left as multiplier bits retire
    logic [31:0] mplier;    // |b|, shifted right as bits retire
    logic [63:0] acc;       // magnitude of the partial product
    logic        neg;       // product must be negated at FINISH
    logic        madd;      // accumulate into HI/LO instead of overwrite

    // Single-cycle datapath
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] sc_result;
    logic        sc_ovf;
    logic        sc_valid;
    logic        is_mul;
    logic        signed_mul;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    // Multiplier datapath
    logic [63:0] addend;
    logic [63:0] prod;
    logic [63:0] hilo_next;

    assign busy = (state != S_IDLE);
    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        sc_result = '0;
        sc_ovf    = 1'b0;
        sc_valid  = 1'b1;
        is_mul    = 1'b0;
        case (alu_control)
            OP_ADD: begin
                sc_result = sum;
                sc_ovf    = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            OP_ADDU: sc_result = sum;
            OP_SUB: begin
                sc_result = diff;
                sc_ovf    = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            OP_SUBU: sc_result = diff;
            OP_AND:  sc_result = a & b;
            OP_OR:   sc_result = a | b;
            OP_XOR:  sc_result = a ^ b;
            OP_NOR:  sc_result = ~(a | b);
            OP_NOT:  sc_result = ~a;
            OP_SLL:  sc_result = b << shamt;
            OP_SRL:  sc_result = b >> shamt;
            OP_SRA:  sc_result = $signed(b) >>> shamt;
            OP_SLT:  sc_result = {31'b0, $signed(a) < $signed(b)};
            OP_SLTU: sc_result = {31'b0, a < b};
            OP_MFHI: sc_result = hi_out;
            OP_MFLO: sc_result = lo_out;
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU: begin
                sc_valid = 1'b0;
                is_mul   = 1'b1;
            end
            default: sc_valid = 1'b0;
        endcase
    end

    // Signed multiplies work on magnitudes; the sign is reapplied at FINISH.
    // Negating 0x80000000 yields 0x80000000, which is the correct magnitude.
    assign signed_mul = (alu_control == OP_MULT) || (alu_control == OP_MADD);
    assign abs_a      = (signed_mul && a[31]) ? (~a + 32'd1) : a;
    assign abs_b      = (signed_mul && b[31]) ? (~b + 32'd1) : b;

    // Partial product for the BITS_PER_CYCLE low multiplier bits.
    always_comb begin
        addend = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) begin
                addend = addend + (mcand << i);
            end
        end
    end

    assign prod      = neg ? (~acc + 64'd1) : acc;
    assign hilo_next = madd ? ({hi_out, lo_out} + prod) : prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            neg      <= 1'b0;
            madd     <= 1'b0;
            done     <= 1'b0;
            invalid  <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            done    <= 1'b0;
            invalid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            mcand  <= {32'b0, abs_a};
                            mplier <= abs_b;
                            acc    <= '0;
                            neg    <= signed_mul && (a[31] ^ b[31]);
                            madd   <= (alu_control == OP_MADD) || (alu_control == OP_MADDU);
                            cnt    <= 6'(K - 1);
                            state  <= S_MUL;
                        end else if (sc_valid) begin
                            result   <= sc_result;
                            zero     <= (sc_result == '0);
                            overflow <= sc_ovf;
                            done     <= 1'b1;
                        end else begin
                            result   <= '0;
                            zero     <= 1'b1;
                            overflow <= 1'b0;
                            invalid  <= 1'b1;
                            done     <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc + addend;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    if (cnt == '0) begin
                        state <= S_FINISH;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                S_FINISH: begin
                    hi_out   <= hilo_next[63:32];
                    lo_out   <= hilo_next[31:0];
                    result   <= hilo_next[31:0];
                    zero     <= (hilo_next[31:0] == '0);
                    overflow <= 1'b0;
                    done     <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_hilo_unit
//   Directed bench for alu_hilo_unit (BITS_PER_CYCLE=1). Expected completions
//   ({invalid, overflow, zero, result}) are queued when an op is driven and
//   compared when done pulses. HI/LO, latency and busy length are checked
//   directly against a small reference model kept in the bench.
// -----------------------------------------------------------------------------
module tb_alu_hilo_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  alu_control;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        invalid;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int total = 0;
    int bad   = 0;

    logic [34:0] exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    alu_hilo_unit #(.BITS_PER_CYCLE(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .alu_control (alu_control),
        .a           (a),
        .b           (b),
        .shamt       (shamt),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .zero        (zero),
        .overflow    (overflow),
        .invalid     (invalid),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit is_mul_code(input logic [5:0] op);
        return (op == 6'b011000) || (op == 6'b011001) ||
               (op == 6'b011100) || (op == 6'b011101);
    endfunction

    function automatic logic [34:0] model_single(input logic [5:0] op,
                                                 input logic [31:0] x,
                                                 input logic [31:0] y,
                                                 input logic [4:0] s);
        logic [32:0] w;
        logic [31:0] r;
        logic        ov;
        ov = 1'b0;
        r  = '0;
        case (op)
            6'b100000: begin
                w  = {x[31], x} + {y[31], y};
                r  = w[31:0];
                ov = (w[32] != w[31]);
            end
            6'b100001: r = x + y;
            6'b100010: begin
                w  = {x[31], x} - {y[31], y};
                r  = w[31:0];
                ov = (w[32] != w[31]);
            end
            6'b100011: r = x - y;
            6'b100100: r = x & y;
            6'b100101: r = x | y;
            6'b100110: r = x ^ y;
            6'b100111: r = ~(x | y);
            6'b101000: r = ~x;
            6'b000000: r = y << s;
            6'b000010: r = y >> s;
            6'b000011: r = $signed(y) >>> s;
            6'b101010: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            6'b101011: r = (x < y) ? 32'd1 : 32'd0;
            6'b010000: r = m_hi;
            6'b010010: r = m_lo;
            default:   return {1'b1, 1'b0, 1'b1, 32'd0};
        endcase
        return {1'b0, ov, (r == 32'd0), r};
    endfunction

    // Updates the HI/LO model and returns the expected completion.
    function automatic logic [34:0] model_mul(input logic [5:0] op,
                                              input logic [31:0] x,
                                              input logic [31:0] y);
        logic [63:0] p;
        logic [63:0] hl;
        if (op == 6'b011000 || op == 6'b011100)
            p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        else
            p = {32'd0, x} * {32'd0, y};
        if (op == 6'b011100 || op == 6'b011101)
            hl = {m_hi, m_lo} + p;
        else
            hl = p;
        m_hi = hl[63:32];
        m_lo = hl[31:0];
        return {1'b0, 1'b0, (m_lo == 32'd0), m_lo};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_done observed=%0h expected=none",
                       {invalid, overflow, zero, result});
            end
            if (exp_q.size() != 0) begin
                logic [34:0] e;
                e = exp_q.pop_front();
                total++;
                assert ({invalid, overflow, zero, result} === e) else begin
                    bad++;
                    $error("FAIL completion observed=%0h expected=%0h",
                           {invalid, overflow, zero, result}, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Drives one op, then scrambles the operand inputs every cycle while
    // waiting for done. With noise set, extra start requests are raised in
    // the middle of a multiply; they must be ignored.
    task automatic issue(input string tag, input logic [5:0] op,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] sh, input int exp_lat,
                         input int exp_busy, input bit noise);
        int cyc;
        int bcyc;
        @(negedge clk);
        alu_control = op;
        a = av;
        b = bv;
        shamt = sh;
        start = 1'b1;
        if (is_mul_code(op)) exp_q.push_back(model_mul(op, av, bv));
        else exp_q.push_back(model_single(op, av, bv, sh));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        bcyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) bcyc++;
            a = $urandom;
            b = $urandom;
            shamt = 5'($urandom_range(0, 31));
            if (noise && cyc >= 5 && cyc <= 10) begin
                start = 1'b1;
                alu_control = 6'b100000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_busy_cycles"}, 64'(bcyc), 64'(exp_busy));
        chk({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    endtask

    // Issues n random single-cycle ops on consecutive cycles.
    task automatic burst(input int n);
        logic [5:0] codes [16];
        codes = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                  6'b100100, 6'b100101, 6'b100110, 6'b100111,
                  6'b101000, 6'b000000, 6'b000010, 6'b000011,
                  6'b101010, 6'b101011, 6'b010000, 6'b010010};
        for (int i = 0; i < n; i++) begin
            logic [5:0]  op;
            logic [31:0] av;
            logic [31:0] bv;
            logic [4:0]  sh;
            @(negedge clk);
            op = codes[$urandom_range(0, 15)];
            av = $urandom;
            bv = $urandom;
            sh = 5'($urandom_range(0, 31));
            alu_control = op;
            a = av;
            b = bv;
            shamt = sh;
            start = 1'b1;
            exp_q.push_back(model_single(op, av, bv, sh));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("burst_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        start = 1'b0;
        alu_control = '0;
        a = '0;
        b = '0;
        shamt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_result", {32'd0, result}, 64'd0);
        chk("reset_zero", {63'd0, zero}, 64'd0);
        chk("reset_hilo", {hi_out, lo_out}, 64'd0);

        // Arithmetic with overflow boundaries
        issue("add_ovf",  6'b100000, 32'h7FFFFFFF, 32'd1, 5'd0, 1, 0, 0);
        issue("addu",     6'b100001, 32'h7FFFFFFF, 32'd1, 5'd0, 1, 0, 0);
        issue("sub_ovf",  6'b100010, 32'h80000000, 32'd1, 5'd0, 1, 0, 0);
        issue("sub_zero", 6'b100010, 32'h12345678, 32'h12345678, 5'd0, 1, 0, 0);
        issue("subu",     6'b100011, 32'd0, 32'd1, 5'd0, 1, 0, 0);
        // Logic
        issue("and", 6'b100100, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0, 1, 0, 0);
        issue("or",  6'b100101, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0, 1, 0, 0);
        issue("xor", 6'b100110, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0, 1, 0, 0);
        issue("nor", 6'b100111, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0, 1, 0, 0);
        issue("not", 6'b101000, 32'h0000FFFF, 32'h0, 5'd0, 1, 0, 0);
        // Shifts and compares
        issue("sra",  6'b000011, 32'h0, 32'h80000000, 5'd4, 1, 0, 0);
        issue("srl",  6'b000010, 32'h0, 32'h80000000, 5'd4, 1, 0, 0);
        issue("sll",  6'b000000, 32'h0, 32'h80000001, 5'd31, 1, 0, 0);
        issue("slt",  6'b101010, 32'hFFFFFFFF, 32'd1, 5'd0, 1, 0, 0);
        issue("sltu", 6'b101011, 32'hFFFFFFFF, 32'd1, 5'd0, 1, 0, 0);

        // MULT -3 * 5: 33 busy cycles, done 34 cycles after acceptance
        issue("mult", 6'b011000, 32'hFFFFFFFD, 32'd5, 5'd0, 34, 33, 0);
        chk("mult_hilo", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFF1);
        issue("mfhi", 6'b010000, 32'h0, 32'h0, 5'd0, 1, 0, 0);
        issue("mflo", 6'b010010, 32'h0, 32'h0, 5'd0, 1, 0, 0);

        // MULTU then MADDU, with ignored start requests during busy
        issue("multu", 6'b011001, 32'hFFFFFFFF, 32'd2, 5'd0, 34, 33, 1);
        issue("maddu", 6'b011101, 32'd1, 32'd1, 5'd0, 34, 33, 1);
        chk("maddu_hilo", {hi_out, lo_out}, 64'h00000001_FFFFFFFF);

        // Signed accumulate across the most-negative operand
        issue("madd", 6'b011100, 32'h80000000, 32'hFFFFFFFF, 5'd0, 34, 33, 0);
        chk("madd_hilo", {hi_out, lo_out}, {m_hi, m_lo});

        // Unsupported codes leave HI/LO alone
        issue("inv_3f", 6'b111111, 32'h1234, 32'h5678, 5'd0, 1, 0, 0);
        issue("inv_01", 6'b000001, 32'h1234, 32'h5678, 5'd0, 1, 0, 0);
        chk("inv_hilo", {hi_out, lo_out}, {m_hi, m_lo});
        @(negedge clk);
        chk("invalid_pulse", {63'd0, invalid}, 64'd0);
        chk("done_pulse", {63'd0, done}, 64'd0);
        chk("result_hold", {32'd0, result}, 64'd0);
        chk("zero_hold", {63'd0, zero}, 64'd1);

        // Back-to-back single-cycle ops
        burst(12);

        // Reset during iteration 10 of a MULT: no completion may follow
        @(negedge clk);
        alu_control = 6'b011000;
        a = 32'd7;
        b = 32'd9;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_mult_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_hilo", {hi_out, lo_out}, 64'd0);
        chk("abort_result", {32'd0, result}, 64'd0);
        repeat (40) @(negedge clk);
        chk("abort_no_done", 64'(exp_q.size()), 64'd0);

        // Still functional after the abort
        issue("post_abort_multu", 6'b011001, 32'h10000, 32'h10000, 5'd0, 34, 33, 0);
        chk("post_abort_hilo", {hi_out, lo_out}, 64'h00000001_00000000);

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
